// File: rtl/seq101_pkg.sv
// seq101_pkg
//   Shared definitions for the "101" frame generator and its detector.
//   Contents:
//     FRAME_LEN_DEF / MAX_COUNT_DEF : default frame length and count ceiling
//     ENC_W                         : width of the raw encode_frame() result
//     det_state_e                   : overlapping "101" detector states S0..S3
//     gen_state_e                   : generator states GEN_IDLE/GEN_SEND/GEN_DONE
//     encode_frame(n)               : frame pattern with n overlapping "101"s
package seq101_pkg;

  localparam int FRAME_LEN_DEF = 10;
  localparam int MAX_COUNT_DEF = 4;

  // Frames up to this many bits can be produced; callers truncate with a cast.
  localparam int ENC_W = 64;

  // S0: nothing useful seen, S1: "1", S2: "10", S3: "101" just completed.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_SEND = 2'd1,
    GEN_DONE = 2'd2
  } gen_state_e;

  // Ones on even indices 0..2n give exactly n overlapping "101" occurrences.
  function automatic logic [ENC_W-1:0] encode_frame(input int unsigned n);
    logic [ENC_W-1:0] f;
    f = '0;
    for (int unsigned i = 32'd0; i < 32'd64; i++) begin
      if ((n != 32'd0) && (i[0] == 1'b0) && (i <= (n << 1))) begin
        f[i] = 1'b1;
      end else begin
        f[i] = 1'b0;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/seq101_frame_generator_monitor.sv
// seq101_monitor
//   Overlapping "101" detector with a saturating occurrence counter.
//   Ports:
//     clk, rst (async, active-high)
//     clear   : synchronous restart of detector state and count
//     bit_in  : serial bit to examine
//     bit_en  : bit_in is consumed this cycle
//     count   : number of "101" occurrences since the last clear (saturates)
module seq101_monitor
  import seq101_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [CNT_W-1:0] count
);

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; S3 falls back to S1/S2 so overlapping patterns count.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S0;
    end else if (bit_en) begin
      case (state_q)
        S0:      state_d = bit_in ? S1 : S0;
        S1:      state_d = bit_in ? S1 : S2;
        S2:      state_d = bit_in ? S3 : S0;
        S3:      state_d = bit_in ? S1 : S2;
        default: state_d = S0;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Count a hit on the S2 -> S3 transition, holding at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (bit_en && bit_in && (state_q == S2) && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq101_frame_generator.sv
// seq101_frame_generator
//   Builds a FRAME_LEN-bit frame holding min(count_req, MAX_COUNT) overlapping
//   "101" occurrences and streams it out LSB (index 0) first over valid/ready,
//   while also presenting it as a parallel word.
//   Ports:
//     clk, rst (async, active-high)
//     start, count_req          : frame request, sampled only when idle
//     ser_bit/ser_valid/ser_last: serial stream, ser_ready accepts a bit
//     word_out                  : current/last frame, held until next start
//     busy, done                : frame in progress / one-cycle completion pulse
//     ovf_sat                   : last captured count_req exceeded MAX_COUNT
//   Optional build macro SEQ101_SELFCHECK_EN adds a seq101_monitor on the
//   accepted bits and a sticky check_err output flagging count mismatches.
module seq101_frame_generator
  import seq101_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int CNT_W     = 3,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     count_req,
  output logic                 ser_bit,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_last,
  output logic [FRAME_LEN-1:0] word_out,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_sat
`ifdef SEQ101_SELFCHECK_EN
  ,
  output logic                 check_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_COUNT);

  gen_state_e           state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [FRAME_LEN-1:0] word_q, word_d;
  logic                 ser_bit_q, ser_bit_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_last_q, ser_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic                 req_ovf_s;
  logic [CNT_W-1:0]     n_sat_s;
  logic [FRAME_LEN-1:0] word_enc_s;
  logic [IDX_W-1:0]     index_nxt_s;

  // Saturate the request and encode the candidate frame.
  always_comb begin
    req_ovf_s   = (count_req > MAX_CNT);
    n_sat_s     = req_ovf_s ? MAX_CNT : count_req;
    word_enc_s  = FRAME_LEN'(encode_frame(32'(n_sat_s)));
    index_nxt_s = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GEN_IDLE;
      index_q     <= '0;
      word_q      <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      word_q      <= word_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GEN_IDLE: begin
        if (start) begin
          state_d = GEN_SEND;
        end else begin
          state_d = GEN_IDLE;
        end
      end
      GEN_SEND: begin
        if (ser_ready && (index_q == LAST_IDX)) begin
          state_d = GEN_DONE;
        end else begin
          state_d = GEN_SEND;
        end
      end
      GEN_DONE: state_d = GEN_IDLE;
      default:  state_d = GEN_IDLE;
    endcase
  end

  // Next values of the registered outputs; they are computed one cycle ahead
  // so ser_valid/ser_bit never depend combinationally on ser_ready.
  always_comb begin
    index_d     = index_q;
    word_d      = word_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      GEN_IDLE: begin
        if (start) begin
          word_d      = word_enc_s;
          index_d     = '0;
          ser_bit_d   = word_enc_s[0];
          ser_valid_d = 1'b1;
          ser_last_d  = (LAST_IDX == '0);
          busy_d      = 1'b1;
          ovf_d       = req_ovf_s;
        end else begin
          ser_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      GEN_SEND: begin
        if (ser_ready && (index_q == LAST_IDX)) begin
          ser_bit_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (ser_ready) begin
          index_d    = index_nxt_s;
          ser_bit_d  = word_q[index_nxt_s];
          ser_last_d = (index_nxt_s == LAST_IDX);
        end else begin
          index_d = index_q;
        end
      end
      GEN_DONE: begin
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        index_d     = '0;
        ser_bit_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign word_out  = word_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf_sat   = ovf_q;

`ifdef SEQ101_SELFCHECK_EN
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] mon_count_s;
  logic             check_err_q, check_err_d;
  logic             start_acc_s;
  logic             bit_acc_s;

  // Frame-start and bit-accept strobes that drive the monitor.
  always_comb begin
    start_acc_s = (state_q == GEN_IDLE) && start;
    bit_acc_s   = (state_q == GEN_SEND) && ser_ready;
  end

  seq101_monitor #(
    .CNT_W(CNT_W)
  ) u_monitor (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_acc_s),
    .bit_in (ser_bit_q),
    .bit_en (bit_acc_s),
    .count  (mon_count_s)
  );

  // Requested count capture and sticky mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= '0;
      check_err_q <= 1'b0;
    end else begin
      n_q         <= n_d;
      check_err_q <= check_err_d;
    end
  end

  // The monitor has absorbed the last bit by the DONE cycle, so compare there.
  always_comb begin
    n_d         = start_acc_s ? n_sat_s : n_q;
    check_err_d = check_err_q;
    if ((state_q == GEN_DONE) && (mon_count_s != n_q)) begin
      check_err_d = 1'b1;
    end else begin
      check_err_d = check_err_q;
    end
  end

  assign check_err = check_err_q;
`endif

endmodule

// File: tb/tb_seq101_frame_generator.sv
module tb_seq101_frame_generator;

  localparam int FL = 10;
  localparam int MC = 4;
  localparam int CW = 3;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] count_req = '0;
  logic          ser_ready = 1'b0;
  logic          ser_bit, ser_valid, ser_last, busy, done, ovf_sat;
  logic [FL-1:0] word_out;
`ifdef SEQ101_SELFCHECK_EN
  logic          check_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq101_frame_generator #(
    .FRAME_LEN(FL),
    .MAX_COUNT(MC),
    .CNT_W(CW),
    .IDX_W(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count_req (count_req),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .word_out  (word_out),
    .busy      (busy),
    .done      (done),
    .ovf_sat   (ovf_sat)
`ifdef SEQ101_SELFCHECK_EN
    ,
    .check_err (check_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: lay n copies of "101" starting at indices 0,2,4,...
  function automatic logic [FL-1:0] model_frame(input int req);
    logic [FL-1:0] w;
    int n;
    n = (req > MC) ? MC : req;
    w = '0;
    for (int k = 0; k < n; k++) begin
      w[2*k]     = 1'b1;
      w[2*k + 1] = 1'b0;
      w[2*k + 2] = 1'b1;
    end
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_bit"},   ser_bit,   0);
    check({tag, "_valid"}, ser_valid, 0);
    check({tag, "_last"},  ser_last,  0);
    check({tag, "_word"},  word_out,  0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_ovf"},   ovf_sat,   0);
  endtask

  // One complete frame; called at a negedge with the generator idle.
  task automatic run_frame(input int req, input bit rand_ready);
    logic [FL-1:0] exp_w;
    int idx, hs, cyc;
    bit rdy;
    exp_w     = model_frame(req);
    count_req = CW'(req);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    count_req = CW'($urandom);
    check("first_valid", ser_valid, 1);
    check("busy", busy, 1);
    check("word", word_out, exp_w);
    check("ovf", ovf_sat, (req > MC));
    idx = 0; hs = 0; cyc = 0;
    while (idx < FL && cyc < 400) begin
      check("valid", ser_valid, 1);
      check("bit", ser_bit, exp_w[idx]);
      check("last", ser_last, (idx == FL - 1));
      check("done_early", done, 0);
      rdy       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_ready = rdy;
      start     = rand_ready ? ($urandom_range(0, 3) == 0) : 1'b0;
      count_req = CW'($urandom);
      @(negedge clk);
      if (rdy) begin
        idx++;
        hs++;
      end
      cyc++;
    end
    ser_ready = 1'b0;
    check("handshakes", hs, FL);
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("valid_in_done", ser_valid, 0);
    // A request during the DONE cycle must be dropped.
    start     = 1'b1;
    count_req = CW'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("done_once", done, 0);
    check("no_restart", ser_valid, 0);
    check("busy_idle", busy, 0);
    check("word_hold", word_out, exp_w);
    check("ovf_hold", ovf_sat, (req > MC));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [FL-1:0] w_n2;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(3, 1'b0);
    check("word_n3", word_out, 10'b0001010101);
    run_frame(0, 1'b0);
    check("word_n0", word_out, 10'b0000000000);
    run_frame(4, 1'b0);
    check("word_n4", word_out, 10'b0101010101);
    run_frame(7, 1'b0);
    check("word_n7", word_out, 10'b0101010101);
    check("ovf_n7", ovf_sat, 1);
    run_frame(2, 1'b1);
    check("ovf_cleared", ovf_sat, 0);

    // Reset while bit index 5 is on the wire.
    w_n2      = model_frame(2);
    count_req = 3'd2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    ser_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_bit5", ser_bit, w_n2[5]);
    check("pre_rst_valid", ser_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    ser_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", ser_valid, 0);
    run_frame(2, 1'b1);

    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(0, 7), 1'b1);
    end

`ifdef SEQ101_SELFCHECK_EN
    for (int r = 0; r < 8; r++) begin
      run_frame(r, 1'b0);
    end
    check("check_err_clean", check_err, 0);
    count_req = 3'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    force dut.word_q = '1;
    ser_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
    end
    check("corrupt_done_seen", done, 1);
    release dut.word_q;
    ser_ready = 1'b0;
    @(negedge clk);
    check("check_err_set", check_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq101_frame_generator.md
Name: seq101_frame_generator

Overview:
- Transmit-side counterpart of the team's "101" switch-frame sequence detector.
- Takes a requested occurrence count and produces a FRAME_LEN-bit frame containing exactly that many overlapping "101" occurrences.
- Emits the frame serially, index 0 first, with a valid/ready handshake, and also presents it as a parallel word.
- Used as the stimulus/loopback source on the board and in detector benches.

Parameters:
- FRAME_LEN, 10: bits per frame; must satisfy FRAME_LEN >= 2*MAX_COUNT+1.
- MAX_COUNT, 4: highest encodable occurrence count; larger requests saturate to it.
- CNT_W, 3: width of count_req and the internal count register.
- IDX_W, 4: width of the bit-index counter; must satisfy 2^IDX_W > FRAME_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- start  in  1  frame request, sampled only in IDLE.
- count_req  in  CNT_W  requested number of "101" occurrences.
- ser_bit  out  1  current serial frame bit.
- ser_valid  out  1  ser_bit is valid.
- ser_ready  in  1  consumer accepts ser_bit this cycle.
- ser_last  out  1  high with the final bit (index FRAME_LEN-1).
- word_out  out  FRAME_LEN  parallel image of the current/last frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last bit is accepted.
- ovf_sat  out  1  latched high if the captured count_req exceeded MAX_COUNT.

Behaviour:
- Reset values (async on rst):
  - ser_bit, ser_valid, ser_last, busy, done, ovf_sat = 0.
  - word_out = 0; state = IDLE; index = 0.
- Encoding: with N = min(count_req, MAX_COUNT):
  - If N=0, every bit is 0.
  - Otherwise bit i = 1 iff i is even and i <= 2N; all other bits are 0.
  - Examples: N=1 gives bits 0..2 = "101"; N=4 gives bits 0..8 = "101010101" and bit 9 = 0.
- State machine: IDLE, SEND, DONE.
- IDLE:
  - On start=1, capture N and set ovf_sat = (count_req > MAX_COUNT).
  - Load word_out with the encoded frame, set index = 0, busy = 1, and go to SEND.
  - Latency: start edge to first ser_valid = 1 cycle.
- SEND:
  - ser_valid = 1; ser_bit = word_out[index]; ser_last = (index == FRAME_LEN-1).
  - If ser_ready=1 and the bit is not last: index increments.
  - If ser_ready=1 and the bit is last: go to DONE.
  - If ser_ready=0: all outputs hold, with no bit skipped or repeated.
- DONE:
  - For exactly one cycle: done = 1, busy = 0, ser_valid = 0.
  - Then return to IDLE. start is not accepted during the DONE cycle.
- Requests while busy: start in SEND or DONE is ignored (not queued); count_req is don't-care outside IDLE.
- Back-to-back frames: minimum period is FRAME_LEN + 2 cycles.
- word_out holds the last frame until the next accepted start.
- Index never exceeds FRAME_LEN-1 (no wrap). Outputs are registered; no combinational path from ser_ready to ser_valid.
- Reset mid-frame: immediate abort, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro: SEQ101_SELFCHECK_EN.
- When defined:
  - Instantiate the seq101_monitor sub-module (overlapping "101" detector) on every accepted bit.
  - After the last bit, compare its count with N.
  - Add output port check_err (1 bit, reset 0), set sticky on mismatch and cleared by rst.
- When undefined: no monitor and no check_err port; all other behaviour is identical.

Decomposition:
- Package seq101_pkg holds:
  - Shared detector/generator state encodings: S0/S1/S2/S3 for the detector, and GEN_IDLE/GEN_SEND/GEN_DONE.
  - Constants FRAME_LEN_DEF=10 and MAX_COUNT_DEF=4.
  - Pure function encode_frame(N) returning the FRAME_LEN-bit pattern.
- Sub-module seq101_monitor:
  - 4-state overlapping "101" detector with bit_in, bit_en, clear and a saturating count.
  - Shared with the bench as the reference model.

Test Plan:
- Reset, then start with count_req=3 and ser_ready tied 1 → bits 0..9 = 1,0,1,0,1,0,1,0,0,0; ser_last on bit 9; done pulses at cycle 12; word_out = 10'b0001010101.
- count_req=0 → ten 0 bits, word_out = 0; count_req=4 → word_out = 10'b0101010101.
- count_req=7 → frame identical to N=4 and ovf_sat = 1; the following frame with count_req=2 clears ovf_sat.
- ser_ready toggled 1,0,0,1 pseudo-randomly → bit sequence unchanged, total handshakes = 10; start pulsed mid-frame → ignored, no second frame.
- rst asserted during bit index 5 → outputs return to 0 asynchronously, no done pulse; a fresh start afterwards produces a full correct frame.
- With SEQ101_SELFCHECK_EN defined, sweep count_req 0..7 → check_err stays 0. Force a corrupted word_out via the bench → check_err = 1 after that frame.
